// File: rtl/sar_adc_pkg.sv
// Shared definitions for the SAR ADC sequencer and the SPI register slave:
// control-register bit positions and the sequencer state encoding.
package sar_adc_pkg;

   localparam int CTRL_ENABLE_BIT = 0;
   localparam int CTRL_START_BIT  = 1;
   localparam int CTRL_CONT_BIT   = 2;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SAMPLE = 3'd1;
   localparam logic [2:0] ST_SETTLE = 3'd2;
   localparam logic [2:0] ST_DECIDE = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      SAMPLE = ST_SAMPLE,
      SETTLE = ST_SETTLE,
      DECIDE = ST_DECIDE,
      DONE   = ST_DONE
   } sar_state_e;

   // Wide enough for SAMPLE_CYCLES up to 255.
   localparam int TIMER_W = 8;

endpackage

// File: rtl/sar_adc_sequencer_if.sv
// Sequencer bus: SPI-slave side (ctrl/status) and analog front-end side
// (track/hold, DAC code, comparator). master = sequencer.
interface sar_adc_sequencer_if #(parameter int WIDTH = 12);
   logic [WIDTH-1:0] ctrl_reg_in;
   logic             eoc_flag_in;
   logic             hw_clear_start;
   logic             sample_en;
   logic [WIDTH-1:0] dac_code;
   logic             comp_in;
   logic [WIDTH-1:0] adc_data;
   logic             adc_busy;
   logic             adc_eoc_pulse;
   logic             overrun;

   modport master (
      input  ctrl_reg_in, eoc_flag_in, comp_in,
      output hw_clear_start, sample_en, dac_code, adc_data, adc_busy, adc_eoc_pulse, overrun
   );
   modport slave (
      output ctrl_reg_in, eoc_flag_in, comp_in,
      input  hw_clear_start, sample_en, dac_code, adc_data, adc_busy, adc_eoc_pulse, overrun
   );
endinterface

// File: rtl/sar_cycle_timer.sv
// Loadable down-counter that stops at zero; tc is high while the count is zero.
// Shared by the sample and DAC-settle waits of the sequencer.
module sar_cycle_timer
   import sar_adc_pkg::*;
#(
   parameter int W = TIMER_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (cnt_q != '0)
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign tc = (cnt_q == '0);

endmodule

// File: rtl/sar_adc_sequencer.sv
// SAR conversion controller: sample/hold then binary search on the DAC code.
// Optional sticky overrun flag enabled by defining SAR_SEQ_OVERRUN_EN.
module sar_adc_sequencer
   import sar_adc_pkg::*;
#(
   parameter int WIDTH         = 12,
   parameter int SAMPLE_CYCLES = 4,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                clk,
   input  logic                reset,
   sar_adc_sequencer_if.master bus
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [TIMER_W-1:0] SAMPLE_LD = TIMER_W'(SAMPLE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] SETTLE_LD = TIMER_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
   // With no settle time each bit is a single DECIDE cycle.
   localparam sar_state_e BIT_ST = (SETTLE_CYCLES == 0) ? DECIDE : SETTLE;

   sar_state_e         state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [IDX_W-1:0]   idx_q, idx_d, idx_m1;
   logic [WIDTH-1:0]   data_q, data_d, dac_q, dac_d;
   logic               sample_en_q, sample_en_d, busy_q, busy_d;
   logic               eoc_q, eoc_d, ovr_q, ovr_d;
   logic               enable, start, cont, clr_start;
   logic               timer_load, timer_tc;
   logic [TIMER_W-1:0] timer_val;

   assign enable = bus.ctrl_reg_in[CTRL_ENABLE_BIT];
   assign start  = bus.ctrl_reg_in[CTRL_START_BIT];
   assign cont   = bus.ctrl_reg_in[CTRL_CONT_BIT];
   assign idx_m1 = idx_q - IDX_W'(1);

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      idx_d     = idx_q;
      data_d    = data_q;
      clr_start = 1'b0;
      case (state_q)
         IDLE:
            if (enable && start) begin
               clr_start = 1'b1;
               state_d   = SAMPLE;
            end
         SAMPLE:
            if (!enable) state_d = IDLE;
            else if (timer_tc) begin
               result_d = WIDTH'(1) << (WIDTH - 1);
               idx_d    = IDX_W'(WIDTH - 1);
               state_d  = BIT_ST;
            end
         SETTLE:
            if (!enable) state_d = IDLE;
            else if (timer_tc) state_d = DECIDE;
         DECIDE:
            if (!enable) state_d = IDLE;
            else begin
               if (!bus.comp_in) result_d[idx_q] = 1'b0;
               if (idx_q != '0) begin
                  result_d[idx_m1] = 1'b1;
                  idx_d            = idx_m1;
                  state_d          = BIT_ST;
               end else begin
                  // Publish on entry to DONE so data is valid alongside the EOC pulse.
                  data_d  = result_d;
                  state_d = DONE;
               end
            end
         DONE:
            state_d = (enable && cont) ? SAMPLE : IDLE;
         default:
            state_d = IDLE;
      endcase

      sample_en_d = (state_d == SAMPLE);
      busy_d      = (state_d != IDLE);
      eoc_d       = (state_d == DONE);
      dac_d       = (state_d == SETTLE || state_d == DECIDE) ? result_d : '0;
      timer_load  = (state_d != state_q);
      timer_val   = (state_d == SAMPLE) ? SAMPLE_LD : SETTLE_LD;

`ifdef SAR_SEQ_OVERRUN_EN
      ovr_d = ovr_q;
      if (clr_start)
         ovr_d = 1'b0;
      else if (state_q == DONE && bus.eoc_flag_in)
         ovr_d = 1'b1;
`else
      ovr_d = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         result_q    <= '0;
         idx_q       <= '0;
         data_q      <= '0;
         dac_q       <= '0;
         sample_en_q <= 1'b0;
         busy_q      <= 1'b0;
         eoc_q       <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         idx_q       <= idx_d;
         data_q      <= data_d;
         dac_q       <= dac_d;
         sample_en_q <= sample_en_d;
         busy_q      <= busy_d;
         eoc_q       <= eoc_d;
         ovr_q       <= ovr_d;
      end
   end

   sar_cycle_timer #(.W(TIMER_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (timer_load),
      .load_val (timer_val),
      .tc       (timer_tc)
   );

   // The clear pulse must land in the accept cycle itself, so it is decoded, not registered.
   assign bus.hw_clear_start = clr_start & ~reset;
   assign bus.sample_en      = sample_en_q;
   assign bus.dac_code       = dac_q;
   assign bus.adc_data       = data_q;
   assign bus.adc_busy       = busy_q;
   assign bus.adc_eoc_pulse  = eoc_q;
   assign bus.overrun        = ovr_q;

`ifndef SAR_SEQ_OVERRUN_EN
   logic unused_eoc_flag;
   assign unused_eoc_flag = bus.eoc_flag_in;
`endif

endmodule

// File: tb/tb_sar_adc_sequencer.sv
// Scoreboard bench for sar_adc_sequencer: an ideal SAR reference (result = input,
// trial codes from the binary-search rule) feeds queues/arrays checked by one monitor.
module tb_sar_adc_sequencer;

   localparam int W     = 12;
   localparam int S_A   = 4;
   localparam int ST_A  = 1;
   localparam int LAT_A = S_A + W * (ST_A + 1) + 1;
`ifdef SAR_SEQ_OVERRUN_EN
   localparam int OVR_EXP = 1;
`else
   localparam int OVR_EXP = 0;
`endif

   typedef struct {
      int data;
      int at;
   } eoc_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic done = 1'b0;
   logic [W-1:0] vin_a = '0;
   logic [W-1:0] vin_b = '0;
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int last_data = 0;

   eoc_t eoc_q[$];
   eoc_t eocb_q[$];
   int   clr_q[$];
   int   clrb_q[$];
   int   exp_dac[int], exp_samp[int], exp_busy[int], exp_data[int], exp_ovr[int];
   int   exp_busy_b[int], exp_data_b[int];
   eoc_t mon_eoc;
   int   mon_clr;

   sar_adc_sequencer_if #(.WIDTH(W)) bus_a ();
   sar_adc_sequencer_if #(.WIDTH(W)) bus_b ();

   assign bus_a.comp_in = (vin_a >= bus_a.dac_code);
   assign bus_b.comp_in = (vin_b >= bus_b.dac_code);

   sar_adc_sequencer #(.WIDTH(W), .SAMPLE_CYCLES(S_A), .SETTLE_CYCLES(ST_A)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a)
   );
   sar_adc_sequencer #(.WIDTH(W), .SAMPLE_CYCLES(1), .SETTLE_CYCLES(0)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Trial code while bit b is being decided: bits above b from the input, bit b set.
   function automatic int trial(int v, int b);
      return ((v >> (b + 1)) << (b + 1)) | (1 << b);
   endfunction

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
      end
   endfunction

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Expected behaviour of one conversion of dut_a accepted (or resumed) at cycle t.
   task automatic schedule(int t, int v, int abort_at, bit clr, bit last);
      int done_c = t + LAT_A;
      int end_c  = (abort_at != 0) ? abort_at : done_c;
      for (int c = t + 1; c <= end_c; c++) begin
         exp_busy[c] = 1;
         exp_samp[c] = (c <= t + S_A) ? 1 : 0;
         if (c <= t + S_A || c == done_c) exp_dac[c] = 0;
         else exp_dac[c] = trial(v, W - 1 - (c - t - S_A - 1) / (ST_A + 1));
      end
      if (clr) clr_q.push_back(t);
      if (abort_at != 0) begin
         exp_busy[abort_at + 1] = 0;
         exp_samp[abort_at + 1] = 0;
         exp_dac[abort_at + 1]  = 0;
      end else begin
         eoc_q.push_back('{v, done_c});
         exp_data[done_c] = v;
         if (last) begin
            exp_busy[done_c + 1] = 0;
            exp_samp[done_c + 1] = 0;
            exp_dac[done_c + 1]  = 0;
         end
      end
   endtask

   task automatic run_single(int v);
      int t;
      vin_a = W'(v);
      bus_a.ctrl_reg_in = 12'h003;
      t = cyc;
      schedule(t, v, 0, 1'b1, 1'b1);
      exp_ovr[t + 1] = 0;
      tick(1);
      bus_a.ctrl_reg_in = 12'h001;
      tick(LAT_A + 2);
      last_data = v;
   endtask

   initial begin
      int t, v;
      bus_a.ctrl_reg_in = '0;
      bus_a.eoc_flag_in = 1'b0;
      bus_b.ctrl_reg_in = '0;
      bus_b.eoc_flag_in = 1'b0;
      tick(3);
      exp_busy[cyc] = 0; exp_samp[cyc] = 0; exp_dac[cyc] = 0;
      exp_data[cyc] = 0; exp_ovr[cyc] = 0; exp_busy_b[cyc] = 0;
      reset = 1'b0;
      tick(1);

      run_single(12'hA5C);
      run_single(12'h000);
      run_single(12'hFFF);
      for (int i = 0; i < 4; i++) run_single(int'($urandom_range(4095, 0)));

      // START without ENABLE must be ignored
      bus_a.ctrl_reg_in = 12'h002;
      tick(5);
      exp_busy[cyc] = 0; exp_data[cyc] = last_data;
      bus_a.ctrl_reg_in = 12'h000;
      tick(1);

      // Continuous: three conversions, CONTINUOUS dropped during the third
      v = 12'h123;
      vin_a = W'(v);
      bus_a.ctrl_reg_in = 12'h007;
      t = cyc;
      schedule(t, v, 0, 1'b1, 1'b0);
      schedule(t + LAT_A, v, 0, 1'b0, 1'b0);
      schedule(t + 2 * LAT_A, v, 0, 1'b0, 1'b1);
      tick(1);
      bus_a.ctrl_reg_in = 12'h005;
      tick(39);
      exp_ovr[t + 50] = 0;
      exp_ovr[t + 65] = OVR_EXP;
      exp_ovr[t + 88] = OVR_EXP;
      bus_a.eoc_flag_in = 1'b1;
      tick(21);
      bus_a.eoc_flag_in = 1'b0;
      tick(7);
      bus_a.ctrl_reg_in = 12'h001;
      tick(22);
      last_data = v;

      run_single(int'($urandom_range(4095, 0)));

      // ENABLE dropped 10 cycles into a conversion
      v = int'($urandom_range(4095, 0));
      vin_a = W'(v);
      bus_a.ctrl_reg_in = 12'h003;
      t = cyc;
      schedule(t, v, t + 10, 1'b1, 1'b0);
      tick(1);
      bus_a.ctrl_reg_in = 12'h001;
      tick(9);
      bus_a.ctrl_reg_in = 12'h000;
      tick(1);
      exp_data[cyc] = last_data;
      tick(3);

      // Synchronous reset in a SETTLE cycle
      v = int'($urandom_range(4095, 0));
      vin_a = W'(v);
      bus_a.ctrl_reg_in = 12'h003;
      t = cyc;
      schedule(t, v, t + 7, 1'b1, 1'b0);
      tick(1);
      bus_a.ctrl_reg_in = 12'h001;
      tick(6);
      reset = 1'b1;
      bus_a.ctrl_reg_in = 12'h000;
      tick(1);
      exp_data[cyc] = 0; exp_ovr[cyc] = 0;
      reset = 1'b0;
      tick(2);

      // SAMPLE_CYCLES=1, SETTLE_CYCLES=0 instance
      vin_b = 12'h800;
      bus_b.ctrl_reg_in = 12'h003;
      t = cyc;
      clrb_q.push_back(t);
      eocb_q.push_back('{12'h800, t + 14});
      exp_data_b[t + 14] = 12'h800;
      exp_busy_b[t + 15] = 0;
      tick(1);
      bus_b.ctrl_reg_in = 12'h001;
      tick(17);
      done = 1'b1;
   end

   always @(negedge clk) begin
      if (bus_a.hw_clear_start) begin
         if (clr_q.size() > 0) begin
            mon_clr = clr_q.pop_front();
            chk("clear_cycle_a", cyc, mon_clr);
         end else begin
            checks++; errors++;
            $display("FAIL clear_unexpected_a: pulse at cycle %0d, none required", cyc);
         end
      end
      if (bus_a.adc_eoc_pulse) begin
         if (eoc_q.size() > 0) begin
            mon_eoc = eoc_q.pop_front();
            chk("eoc_cycle_a", cyc, mon_eoc.at);
            chk("eoc_data_a", bus_a.adc_data, mon_eoc.data);
         end else begin
            checks++; errors++;
            $display("FAIL eoc_unexpected_a: pulse at cycle %0d, none required", cyc);
         end
      end
      if (exp_dac.exists(cyc))  chk("dac_code_a", bus_a.dac_code, exp_dac[cyc]);
      if (exp_samp.exists(cyc)) chk("sample_en_a", bus_a.sample_en, exp_samp[cyc]);
      if (exp_busy.exists(cyc)) chk("busy_a", bus_a.adc_busy, exp_busy[cyc]);
      if (exp_data.exists(cyc)) chk("adc_data_a", bus_a.adc_data, exp_data[cyc]);
      if (exp_ovr.exists(cyc))  chk("overrun_a", bus_a.overrun, exp_ovr[cyc]);

      if (bus_b.hw_clear_start) begin
         if (clrb_q.size() > 0) begin
            mon_clr = clrb_q.pop_front();
            chk("clear_cycle_b", cyc, mon_clr);
         end else begin
            checks++; errors++;
            $display("FAIL clear_unexpected_b: pulse at cycle %0d, none required", cyc);
         end
      end
      if (bus_b.adc_eoc_pulse) begin
         if (eocb_q.size() > 0) begin
            mon_eoc = eocb_q.pop_front();
            chk("eoc_cycle_b", cyc, mon_eoc.at);
            chk("eoc_data_b", bus_b.adc_data, mon_eoc.data);
         end else begin
            checks++; errors++;
            $display("FAIL eoc_unexpected_b: pulse at cycle %0d, none required", cyc);
         end
      end
      if (exp_busy_b.exists(cyc)) chk("busy_b", bus_b.adc_busy, exp_busy_b[cyc]);
      if (exp_data_b.exists(cyc)) chk("adc_data_b", bus_b.adc_data, exp_data_b[cyc]);

      if (done) begin
         chk("eoc_pending_a", eoc_q.size(), 0);
         chk("clear_pending_a", clr_q.size(), 0);
         chk("eoc_pending_b", eocb_q.size(), 0);
         chk("clear_pending_b", clrb_q.size(), 0);
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $finish;
      end else if (cyc > 20000) begin
         errors++;
         $display("FAIL watchdog: cycle %0d reached without completion", cyc);
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $fatal(1, "watchdog expired");
      end
   end

endmodule
